// File: rtl/cpu_pkg.sv
// Shared pipeline control definitions: PC-select codes, trap vectors,
// hazard-sequencer state encodings and small decode helpers.
package cpu_pkg;

  localparam logic [2:0] PCSEL_SEQ    = 3'd0;
  localparam logic [2:0] PCSEL_BRANCH = 3'd1;
  localparam logic [2:0] PCSEL_JUMP   = 3'd2;
  localparam logic [2:0] PCSEL_JR     = 3'd3;
  localparam logic [2:0] PCSEL_IRQ    = 3'd4;
  localparam logic [2:0] PCSEL_EXC    = 3'd5;

  localparam logic [31:0] IRQ_VEC_DEF = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC_DEF = 32'h8000_0008;
  localparam int          CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_USER   = 2'd0,
    ST_PEND   = 2'd1,
    ST_KERNEL = 2'd2
  } hz_state_e;

  // A load in EX feeding either source of the ID instruction; $0 never hazards.
  function automatic logic load_use_f(
    input logic       memread,
    input logic       valid,
    input logic [4:0] idex_rt,
    input logic [4:0] rs,
    input logic [4:0] rt
  );
    return memread & valid & (idex_rt != 5'd0) &
           ((idex_rt == rs) | (idex_rt == rt));
  endfunction

  // Return address for an instruction that must not be re-executed.
  function automatic logic [31:0] next_pc_f(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter
  import cpu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  // Next count: step by one unless already pinned at the top value
  always_comb begin
    value_d = value_q;
    if (inc && (value_q != {CNT_W{1'b1}})) begin
      value_d = value_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      value_d = value_q;
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, redirect and interrupt sequencer for the 5-stage pipeline.
// Picks exactly one action per cycle by fixed priority and drives the
// PC-select / stall / flush / bubble controls combinationally; the
// user/pending/kernel state and EPC are registered.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF,
  parameter int          CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ifid_valid,
  input  logic [31:0]      ifid_pc,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             ex_branch_tkn,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             id_undef,
  input  logic             irq,
  output logic [2:0]       pc_sel,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             epc_we,
  output logic [31:0]      epc,
  output logic             irq_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The PC mux fetches the vectors directly; they must be word aligned.
  if ((IRQ_VEC[1:0] != 2'b00) || (EXC_VEC[1:0] != 2'b00)) begin : g_bad_vec
    $error("pipe_hazard_ctrl: trap vectors must be word aligned");
  end

  hz_state_e   state_q;
  logic [31:0] epc_q;

  logic        load_use_s;
  logic        irq_take_s;
  logic        take_exc_s;
  logic        take_irq_s;
  logic        stall_inc_s;
  logic        flush_inc_s;
  logic [2:0]  pc_sel_s;
  logic        pc_hold_s;
  logic        ifid_hold_s;
  logic        ifid_flush_s;
  logic        idex_bubble_s;

  assign load_use_s = load_use_f(idex_memread, ifid_valid, idex_rt, ifid_rs, ifid_rt);
  // Only a real user-mode instruction may be squashed for IRQ entry, and never
  // one that is itself waiting on a load.
  assign irq_take_s = (state_q == ST_PEND) & ifid_valid & ~ifid_pc[31] & ~load_use_s;

  // Priority decode: exactly one pipeline action per cycle
  always_comb begin
    pc_sel_s      = PCSEL_SEQ;
    pc_hold_s     = 1'b0;
    ifid_hold_s   = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    take_exc_s    = 1'b0;
    take_irq_s    = 1'b0;
    stall_inc_s   = 1'b0;
    flush_inc_s   = 1'b0;
    if (ex_branch_tkn) begin
      // ID holds a wrong-path instruction: nothing it raises is honoured.
      pc_sel_s      = PCSEL_BRANCH;
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
      flush_inc_s   = 1'b1;
    end else if (id_undef && ifid_valid) begin
      pc_sel_s      = PCSEL_EXC;
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
      take_exc_s    = 1'b1;
      flush_inc_s   = 1'b1;
    end else if (irq_take_s) begin
      pc_sel_s      = PCSEL_IRQ;
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
      take_irq_s    = 1'b1;
      flush_inc_s   = 1'b1;
    end else if (load_use_s) begin
      // A jump waiting on its operand stays parked in ID here too.
      pc_hold_s     = 1'b1;
      ifid_hold_s   = 1'b1;
      idex_bubble_s = 1'b1;
      stall_inc_s   = 1'b1;
    end else if ((id_jump || id_jr) && ifid_valid) begin
      pc_sel_s      = id_jump ? PCSEL_JUMP : PCSEL_JR;
      ifid_flush_s  = 1'b1;
      flush_inc_s   = 1'b1;
    end else begin
      pc_sel_s      = PCSEL_SEQ;
    end
  end

  // Privilege/interrupt state and exception PC capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_USER;
      epc_q   <= 32'h0000_0000;
    end else if (take_exc_s) begin
      // Nested undefined in kernel still vectors and overwrites EPC.
      state_q <= ST_KERNEL;
      epc_q   <= next_pc_f(ifid_pc);
    end else if (take_irq_s) begin
      // The squashed instruction re-executes after return.
      state_q <= ST_KERNEL;
      epc_q   <= ifid_pc;
    end else begin
      epc_q <= epc_q;
      case (state_q)
        ST_USER: begin
          if (irq && !ifid_pc[31]) begin
            state_q <= ST_PEND;
          end else begin
            state_q <= ST_USER;
          end
        end
        ST_PEND: begin
          if (!irq) begin
            state_q <= ST_USER;
          end else begin
            state_q <= ST_PEND;
          end
        end
        ST_KERNEL: begin
          // First valid user-space instruction marks the return from the handler.
          if (ifid_valid && !ifid_pc[31]) begin
            state_q <= ST_USER;
          end else begin
            state_q <= ST_KERNEL;
          end
        end
        default: begin
          state_q <= ST_USER;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc_s),
    .value (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc_s),
    .value (flush_cnt)
  );

  assign pc_sel      = pc_sel_s;
  assign pc_hold     = pc_hold_s;
  assign ifid_hold   = ifid_hold_s;
  assign ifid_flush  = ifid_flush_s;
  assign idex_bubble = idex_bubble_s;
  assign epc_we      = take_exc_s | take_irq_s;
  assign irq_ack     = take_irq_s;
  assign epc         = epc_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver applies one directed
// vector per cycle at the falling edge and queues the hand-computed response;
// the monitor samples 3 ns later and compares against the queue head.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        idex_memread;
  logic [4:0]  idex_rt;
  logic        ex_branch_tkn;
  logic        id_jump;
  logic        id_jr;
  logic        id_undef;
  logic        irq;
  logic [2:0]  pc_sel;
  logic        pc_hold;
  logic        ifid_hold;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        epc_we;
  logic [31:0] epc;
  logic        irq_ack;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_memread(idex_memread),
    .idex_rt(idex_rt), .ex_branch_tkn(ex_branch_tkn), .id_jump(id_jump),
    .id_jr(id_jr), .id_undef(id_undef), .irq(irq), .pc_sel(pc_sel),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .epc_we(epc_we), .epc(epc), .irq_ack(irq_ack),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // flags = {pc_hold, ifid_hold, ifid_flush, idex_bubble, epc_we, irq_ack}
  localparam logic [5:0] F_NONE  = 6'b000000;
  localparam logic [5:0] F_STALL = 6'b110100;
  localparam logic [5:0] F_BR    = 6'b001100;
  localparam logic [5:0] F_JMP   = 6'b001000;
  localparam logic [5:0] F_EXC   = 6'b001110;
  localparam logic [5:0] F_IRQ   = 6'b001111;

  typedef struct {
    logic [2:0]  pc_sel;
    logic [5:0]  flags;
    logic [31:0] epc;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_epc   = 32'h0;
  logic [15:0] exp_stall = 16'h0;
  logic [15:0] exp_flush = 16'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare outputs with the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("pc_sel", {29'd0, pc_sel}, {29'd0, e.pc_sel});
      chk("flags", {26'd0, pc_hold, ifid_hold, ifid_flush, idex_bubble, epc_we, irq_ack},
          {26'd0, e.flags});
      chk("epc", epc, e.epc);
      chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.stall});
      chk("flush_cnt", {16'd0, flush_cnt}, {16'd0, e.flush});
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                       input logic [4:0] rt, input logic mr, input logic [4:0] xrt,
                       input logic br, input logic j, input logic jr,
                       input logic und, input logic iq);
    ifid_valid = v; ifid_pc = pc; ifid_rs = rs; ifid_rt = rt;
    idex_memread = mr; idex_rt = xrt; ex_branch_tkn = br;
    id_jump = j; id_jr = jr; id_undef = und; irq = iq;
  endtask

  // One cycle: drive inputs, queue expected response, advance bookkeeping.
  task automatic vec(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                     input logic [4:0] rt, input logic mr, input logic [4:0] xrt,
                     input logic br, input logic j, input logic jr,
                     input logic und, input logic iq,
                     input logic [2:0] sel, input logic [5:0] fl, input logic [31:0] nepc);
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    drive(v, pc, rs, rt, mr, xrt, br, j, jr, und, iq);
    e.pc_sel = sel; e.flags = fl; e.epc = exp_epc;
    e.stall = exp_stall; e.flush = exp_flush;
    sb_q.push_back(e);
    if (fl[5] && (exp_stall != 16'hFFFF)) exp_stall = exp_stall + 16'd1;
    if (fl[3] && (exp_flush != 16'hFFFF)) exp_flush = exp_flush + 16'd1;
    if (fl[1]) exp_epc = nepc;
  endtask

  // Reset asserted mid-cycle: everything must drop to zero at once.
  task automatic vec_reset_mid(input logic v, input logic [31:0] pc, input logic iq);
    exp_t e;
    @(negedge clk);
    drive(v, pc, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, iq);
    #1 reset = 1'b1;
    exp_epc = 32'h0; exp_stall = 16'h0; exp_flush = 16'h0;
    e.pc_sel = 3'd0; e.flags = F_NONE; e.epc = 32'h0; e.stall = 16'h0; e.flush = 16'h0;
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t e0;
    reset = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // reset state
    @(negedge clk);
    e0.pc_sel = 3'd0; e0.flags = F_NONE; e0.epc = 32'h0; e0.stall = 16'h0; e0.flush = 16'h0;
    sb_q.push_back(e0);

    //  v   pc             rs    rt    mr    xrt   br    j     jr    und   irq   sel   flags    new epc
    vec(1'b1, 32'h0000_0100, 5'd8, 5'd9, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, F_STALL, 32'h0); // lw $t0 / add $t0
    vec(1'b1, 32'h0000_0104, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, F_NONE,  32'h0); // lw to $0
    vec(1'b1, 32'h0000_0108, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, F_STALL, 32'h0); // rt match
    vec(1'b0, 32'h0000_010C, 5'd8, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, F_NONE,  32'h0); // bubble in ID
    vec(1'b1, 32'h0000_0110, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, F_BR,    32'h0); // branch beats jump
    vec(1'b1, 32'h0000_0114, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, F_JMP,   32'h0); // jump
    vec(1'b1, 32'h0000_0118, 5'd31, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, F_JMP,  32'h0); // jr
    vec(1'b1, 32'h0000_011C, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, F_STALL, 32'h0); // jr waits on load
    vec(1'b0, 32'h0000_0120, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, F_NONE,  32'h0); // jump in bubble ignored
    // IRQ entry: USER->PEND, then take
    vec(1'b1, 32'h0000_0040, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, F_NONE,  32'h0);
    vec(1'b1, 32'h0000_0040, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, F_IRQ,   32'h0000_0040);
    // Kernel: masked even with irq high
    vec(1'b1, 32'h8000_0004, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, F_NONE,  32'h0);
    vec(1'b1, 32'h8000_0100, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, F_NONE,  32'h0);
    vec(1'b1, 32'h8000_0100, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, F_NONE,  32'h0);
    // Return to user with irq still high: KERNEL->USER->PEND->take
    vec(1'b1, 32'h0000_0044, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, F_NONE,  32'h0);
    vec(1'b1, 32'h0000_0044, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, F_NONE,  32'h0);
    vec(1'b1, 32'h0000_0044, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, F_IRQ,   32'h0000_0044);
    // Undefined instruction while IRQ pending: exception wins, no ack
    vec(1'b1, 32'h0000_0048, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, F_NONE,  32'h0);
    vec(1'b1, 32'h0000_0010, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, F_NONE,  32'h0);
    vec(1'b1, 32'h0000_0010, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, F_EXC,   32'h0000_0014);
    // Nested exception in kernel overwrites EPC; wrong-path undef ignored
    vec(1'b1, 32'h8000_0020, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, F_EXC,   32'h8000_0024);
    vec(1'b1, 32'h8000_0030, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, F_BR,    32'h0);
    // Pending IRQ held off by a load-use stall
    vec(1'b1, 32'h0000_0050, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, F_NONE,  32'h0);
    vec(1'b1, 32'h0000_0050, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, F_NONE,  32'h0);
    vec(1'b1, 32'h0000_0050, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, F_STALL, 32'h0);
    vec(1'b1, 32'h0000_0050, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, F_IRQ,   32'h0000_0050);
    // irq drops before it can be taken: PEND->USER, no later take
    vec(1'b1, 32'h0000_0060, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, F_NONE,  32'h0);
    vec(1'b1, 32'h0000_0060, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, F_NONE,  32'h0);
    vec(1'b0, 32'h0000_0060, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, F_NONE,  32'h0);
    vec(1'b1, 32'h0000_0060, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, F_NONE,  32'h0);

    // Saturation: the stall counter must stop at 16'hFFFF
    for (int i = 0; i < 65540; i++) begin
      vec(1'b1, 32'h0000_0200, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, F_STALL, 32'h0);
    end

    // Reset while PEND, then re-latch from level irq
    vec(1'b1, 32'h0000_0070, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, F_NONE,  32'h0);
    vec_reset_mid(1'b1, 32'h0000_0070, 1'b1);
    vec(1'b1, 32'h0000_0070, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, F_NONE,  32'h0);
    vec(1'b1, 32'h0000_0070, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, F_IRQ,   32'h0000_0070);
    vec(1'b1, 32'h8000_0004, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, F_NONE,  32'h0);

    repeat (2) @(negedge clk);
    #5;
    chk("scoreboard_drain", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
